// File: rtl/alu_operand_deserializer.sv
// Collects 1/2/4/8 frame bytes into a 64-bit ALU operand with selectable byte order
// and sign/zero extension, then offers it with its opcode on a ready/valid port.
module alu_operand_deserializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [7:0]  out_opcode,
  output logic        aborted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  idx_q, idx_d;
  logic        aborted_q, aborted_d;

  logic [2:0]  last_idx;
  logic [2:0]  lane;
  logic [63:0] placed;

  function automatic logic [2:0] size_last(input logic [1:0] sz);
    case (sz)
      2'd0:    size_last = 3'd0;
      2'd1:    size_last = 3'd1;
      2'd2:    size_last = 3'd3;
      default: size_last = 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] put_byte(input logic [63:0] acc, input logic [2:0] ln,
                                           input logic [7:0] b);
    logic [63:0] r;
    r = acc;
    r[{ln, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Upper bits follow the top collected bit only for signed operands narrower than 64 bits.
  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic sgn);
    case (sz)
      2'd0:    extend = {{56{sgn & v[7]}},  v[7:0]};
      2'd1:    extend = {{48{sgn & v[15]}}, v[15:0]};
      2'd2:    extend = {{32{sgn & v[31]}}, v[31:0]};
      default: extend = v;
    endcase
  endfunction

  assign last_idx = size_last(op_q[7:6]);
  assign lane     = op_q[4] ? (last_idx - idx_q) : idx_q;
  assign placed   = put_byte(acc_q, lane, in_data);

  // Next-state and datapath update for the IDLE/LOAD/HOLD sequence.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    idx_d     = idx_q;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_opcode;
          acc_d   = 64'd0;
          idx_d   = 3'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          idx_d     = 3'd0;
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (in_valid) begin
          if (idx_q == last_idx) begin
            acc_d   = extend(placed, op_q[7:6], op_q[5]);
            idx_d   = 3'd0;
            state_d = ST_HOLD;
          end else begin
            acc_d   = placed;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= 64'd0;
      op_q      <= 8'd0;
      idx_q     <= 3'd0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign in_ready   = (state_q == ST_LOAD);
  assign out_valid  = (state_q == ST_HOLD);
  assign out_value  = acc_q;
  assign out_opcode = op_q;
  assign aborted    = aborted_q;

endmodule
